// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU encodings: load/store type codes, FSM states, access sizes and
// the request fields latched when an access is accepted.
package lsu_ctrl_pkg;

   localparam int XLEN   = 64;
   localparam int NBYTES = XLEN / 8;
   localparam int OFF_W  = $clog2(NBYTES);

   // Load type codes from the decoder; bit 2 set means zero-extend (ld excepted)
   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LH  = 3'b010;
   localparam logic [2:0] LD_LW  = 3'b011;
   localparam logic [2:0] LD_LD  = 3'b100;
   localparam logic [2:0] LD_LBU = 3'b101;
   localparam logic [2:0] LD_LHU = 3'b110;
   localparam logic [2:0] LD_LWU = 3'b111;

   // Store type codes from the decoder
   localparam logic [2:0] ST_SB = 3'b100;
   localparam logic [2:0] ST_SH = 3'b101;
   localparam logic [2:0] ST_SW = 3'b110;
   localparam logic [2:0] ST_SD = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} acc_size_e;

   // Fields of an accepted access needed after the bus handshake
   typedef struct packed {
      logic             is_store;
      logic [2:0]       ld_type;
      logic [OFF_W-1:0] off;
   } lsu_req_t;

   function automatic acc_size_e store_size(input logic [2:0] t);
      case (t)
         ST_SB:   return SZ_B;
         ST_SH:   return SZ_H;
         ST_SW:   return SZ_W;
         ST_SD:   return SZ_D;
         default: return acc_size_e'(t[1:0]);
      endcase
   endfunction

   function automatic acc_size_e load_size(input logic [2:0] t);
      case (t)
         LD_LB, LD_LBU: return SZ_B;
         LD_LH, LD_LHU: return SZ_H;
         LD_LW, LD_LWU: return SZ_W;
         LD_LD:         return SZ_D;
         default:       return SZ_D;
      endcase
   endfunction

   // Byte strobes for an access of the given size at lane 0
   function automatic logic [NBYTES-1:0] size_mask(input acc_size_e sz);
      case (sz)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic misaligned(input acc_size_e sz, input logic [OFF_W-1:0] off);
      case (sz)
         SZ_H:    return off[0];
         SZ_W:    return |off[1:0];
         SZ_D:    return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result formatting: shift the aligned doubleword down to the access
// byte offset, truncate to the access size and sign/zero extend.
module lsu_load_ext
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]       load_type,
   input  logic [OFF_W-1:0] off,
   input  logic [XLEN-1:0]  rdata,
   output logic [XLEN-1:0]  result
);

   logic [XLEN-1:0] sh;
   logic            sx;

   // Shift, truncate, extend; code bit 2 clear selects sign extension
   always_comb begin
      sh = rdata >> {off, 3'b000};
      sx = ~load_type[2];
      case (load_type[1:0])
         2'b01:   result = {{56{sx & sh[7]}},  sh[7:0]};
         2'b10:   result = {{48{sx & sh[15]}}, sh[15:0]};
         2'b11:   result = {{32{sx & sh[31]}}, sh[31:0]};
         default: result = sh;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one access at a time, IDLE -> REQ -> WAIT -> DONE.
// Optional LSU_MISALIGN_CHK_EN: size-misaligned accesses skip the bus and
// complete with done_err set; without it done_err is tied low.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_mem_read,
   input  logic              req_mem_write,
   input  logic [2:0]        req_load_type,
   input  logic [2:0]        req_store_type,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_wen,
   output logic [NBYTES-1:0] mem_wmask,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              done_valid,
   output logic [XLEN-1:0]   done_rdata,
   output logic              done_err
);

   lsu_state_e        state, state_nxt;
   lsu_req_t          req_q;
   logic [XLEN-1:0]   addr_q, wdata_q, rdata_q, ld_result;
   logic [NBYTES-1:0] wmask_q;
   logic              wen_q;
   logic [OFF_W-1:0]  req_off;
   logic              is_access, bad_align, accept;

   assign req_off   = req_addr[OFF_W-1:0];
   assign is_access = req_mem_read | req_mem_write;
   assign accept    = (state == S_IDLE) & req_valid & is_access & ~bad_align;

`ifdef LSU_MISALIGN_CHK_EN
   acc_size_e req_size;
   logic      err_q;

   assign req_size  = req_mem_write ? store_size(req_store_type) : load_size(req_load_type);
   assign bad_align = is_access & misaligned(req_size, req_off);

   // Error flag follows each IDLE decision so it is valid for the DONE cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                         err_q <= 1'b0;
      else if (state == S_IDLE && req_valid) err_q <= bad_align;
   end

   assign done_err = (state == S_DONE) & err_q;
`else
   assign bad_align = 1'b0;
   assign done_err  = 1'b0;
`endif

   // State register; reset drops any in-flight bus transaction
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: no-op and rejected accesses go straight to DONE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req_valid) state_nxt = accept ? S_REQ : S_DONE;
         S_REQ:  if (mem_ready) state_nxt = S_WAIT;
         S_WAIT: if (mem_rsp_valid) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latch bus fields on acceptance; capture the completion data
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_q   <= '0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wmask_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            req_q   <= '{is_store: req_mem_write, ld_type: req_load_type, off: req_off};
            addr_q  <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            wen_q   <= req_mem_write;
            wmask_q <= req_mem_write ? (size_mask(store_size(req_store_type)) << req_off) : '0;
            wdata_q <= req_mem_write ? (req_wdata << {req_off, 3'b000}) : '0;
         end
         if (state == S_IDLE && req_valid && !accept)
            rdata_q <= '0;
         else if (state == S_WAIT && mem_rsp_valid)
            rdata_q <= req_q.is_store ? '0 : ld_result;
      end
   end

   lsu_load_ext u_load_ext (
      .load_type (req_q.ld_type),
      .off       (req_q.off),
      .rdata     (mem_rdata),
      .result    (ld_result)
   );

   assign req_ready  = (state == S_IDLE);
   assign mem_valid  = (state == S_REQ);
   assign mem_addr   = addr_q;
   assign mem_wen    = wen_q;
   assign mem_wmask  = wmask_q;
   assign mem_wdata  = wdata_q;
   assign done_valid = (state == S_DONE);
   assign done_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected bus requests and
// completions; independent monitors pop and compare them.
module tb_lsu_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_mem_read, req_mem_write;
   logic [2:0]  req_load_type, req_store_type;
   logic [63:0] req_addr, req_wdata;
   logic        mem_valid, mem_ready, mem_wen, mem_rsp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        done_valid, done_err;
   logic [63:0] done_rdata;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [7:0]  wmask;
      logic [63:0] wdata;
      int          vcyc;
   } bus_exp_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          cyc;
   } done_exp_t;

   bus_exp_t    bus_q[$];
   done_exp_t   done_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ready_wait = 0;
   bit          bus_drop = 1'b0;
   logic [63:0] bus_rdata = '0;
   int          inject_req = 0;

   lsu_ctrl dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_mem_read   (req_mem_read),
      .req_mem_write  (req_mem_write),
      .req_load_type  (req_load_type),
      .req_store_type (req_store_type),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wmask      (mem_wmask),
      .mem_wdata      (mem_wdata),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rdata      (mem_rdata),
      .done_valid     (done_valid),
      .done_rdata     (done_rdata),
      .done_err       (done_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus model: ready after ready_wait cycles of mem_valid, response next cycle
   initial begin : responder
      int wcnt;
      int inject_done;
      wcnt = 0;
      inject_done = 0;
      mem_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clock); #1;
         mem_rsp_valid = 1'b0;
         if (!reset_n) begin
            mem_ready = 1'b0;
            wcnt = 0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
            if (!bus_drop) begin
               mem_rsp_valid = 1'b1;
               mem_rdata = bus_rdata;
            end
         end else if (mem_valid) begin
            if (wcnt >= ready_wait) begin
               mem_ready = 1'b1;
               wcnt = 0;
            end else wcnt++;
         end
         if (inject_req != inject_done) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = bus_rdata;
            inject_done++;
         end
      end
   end

   // Bus monitor: compare each accepted request and its hold duration
   initial begin : bus_mon
      int cnt;
      bit stable;
      logic [63:0] a0, d0;
      logic [7:0]  m0;
      logic        w0;
      bus_exp_t    e;
      cnt = 0;
      stable = 1'b1;
      forever begin
         @(negedge clock);
         if (!reset_n) cnt = 0;
         else if (mem_valid) begin
            if (cnt == 0) begin
               a0 = mem_addr; d0 = mem_wdata; m0 = mem_wmask; w0 = mem_wen; stable = 1'b1;
            end else if (mem_addr !== a0 || mem_wdata !== d0 || mem_wmask !== m0 || mem_wen !== w0)
               stable = 1'b0;
            cnt++;
            if (mem_ready) begin
               if (bus_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL bus_unexpected: request at %h, none expected", mem_addr);
               end else begin
                  e = bus_q.pop_front();
                  chk("bus_addr", mem_addr, e.addr);
                  chk("bus_wen", mem_wen, e.wen);
                  chk("bus_wmask", mem_wmask, e.wmask);
                  if (e.wen) chk("bus_wdata", mem_wdata, e.wdata);
                  chk("bus_valid_cycles", cnt, e.vcyc);
                  chk("bus_stable", stable, 1);
               end
               cnt = 0;
            end
         end
      end
   end

   // Completion monitor: one-cycle pulse, data, error flag and latency
   initial begin : done_mon
      bit prev;
      done_exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (done_valid) begin
            if (prev) begin
               checks++; errors++;
               $display("FAIL done_pulse: done_valid high two cycles, got 1 expected 0");
            end
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: done_valid with rdata %h, none expected", done_rdata);
            end else begin
               e = done_q.pop_front();
               chk("done_rdata", done_rdata, e.rdata);
               chk("done_err", done_err, e.err);
               chk("done_cycle", cyc, e.cyc);
            end
         end
         prev = done_valid;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic issue(input logic rd, input logic wr, input logic [2:0] lt, input logic [2:0] st,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                        input int rw, input bit has_bus, input logic [7:0] e_mask,
                        input logic [63:0] e_wdata, input bit has_done, input logic [63:0] e_rdata,
                        input logic e_err, input int lat);
      int n;
      bus_exp_t  b;
      done_exp_t d;
      n = 0;
      while (!req_ready && n < 100) begin @(posedge clock); #1; n++; end
      chk("issue_ready", req_ready, 1);
      ready_wait = rw;
      bus_rdata = rdata;
      if (has_bus) begin
         b.addr = addr & ~64'h7; b.wen = wr; b.wmask = e_mask; b.wdata = e_wdata; b.vcyc = rw + 1;
         bus_q.push_back(b);
      end
      if (has_done) begin
         d.rdata = e_rdata; d.err = e_err; d.cyc = cyc + lat;
         done_q.push_back(d);
      end
      req_valid = 1'b1; req_mem_read = rd; req_mem_write = wr;
      req_load_type = lt; req_store_type = st; req_addr = addr; req_wdata = wdata;
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic store(input logic [2:0] st, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] e_mask, input logic [63:0] e_wdata);
      issue(1'b0, 1'b1, 3'b000, st, addr, wdata, 64'h0, 0, 1'b1, e_mask, e_wdata, 1'b1, 64'h0, 1'b0, 3);
   endtask

   task automatic load(input logic [2:0] lt, input logic [63:0] addr, input logic [63:0] rdata,
                       input int rw, input logic [63:0] e_rdata);
      issue(1'b1, 1'b0, lt, 3'b000, addr, 64'h0, rdata, rw, 1'b1, 8'h00, 64'h0, 1'b1, e_rdata, 1'b0, 3 + rw);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((!req_ready || done_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
         @(posedge clock); #1; n++;
      end
      chk("wait_idle", (n < 200), 1);
   endtask

   initial begin : stim
      int n;
      reset_n = 1'b0; req_valid = 1'b0; req_mem_read = 1'b0; req_mem_write = 1'b0;
      req_load_type = '0; req_store_type = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_done_rdata", done_rdata, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("rst_req_ready", req_ready, 1);

      store(3'b111, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);
      store(3'b100, 64'h8000_0005, 64'h0000_0000_0000_00AB, 8'h20, 64'h0000_AB00_0000_0000);
      load(3'b001, 64'h8000_0003, 64'h0000_0000_8000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80);
      load(3'b101, 64'h8000_0003, 64'h0000_0000_8000_0000, 0, 64'h0000_0000_0000_0080);
      load(3'b011, 64'h8000_0004, 64'h8765_4321_0000_0000, 3, 64'hFFFF_FFFF_8765_4321);
      wait_idle();
      repeat (3) @(posedge clock);
      #1;
      chk("rdata_hold", done_rdata, 64'hFFFF_FFFF_8765_4321);
      load(3'b010, 64'h1000_0002, 64'h0000_0000_1234_0000, 0, 64'h0000_0000_0000_1234);
      load(3'b010, 64'h1000_0002, 64'h0000_0000_FEDC_0000, 1, 64'hFFFF_FFFF_FFFF_FEDC);
      load(3'b110, 64'h1000_0002, 64'h0000_0000_FEDC_0000, 0, 64'h0000_0000_0000_FEDC);
      load(3'b111, 64'h1000_0000, 64'h0000_0000_8765_4321, 0, 64'h0000_0000_8765_4321);
      load(3'b100, 64'h0000_0018, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'hDEAD_BEEF_CAFE_F00D);
      store(3'b101, 64'h0000_0006, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000);
      store(3'b110, 64'h0000_0004, 64'hFFFF_FFFF_1234_5678, 8'hF0, 64'h1234_5678_0000_0000);
      // Read and write together behave as a store
      issue(1'b1, 1'b1, 3'b001, 3'b111, 64'h0000_0020, 64'h0102_0304_0506_0708, 64'hFFFF_FFFF_FFFF_FFFF,
            0, 1'b1, 8'hFF, 64'h0102_0304_0506_0708, 1'b1, 64'h0, 1'b0, 3);
      // Neither read nor write: straight to DONE with zero data
      issue(1'b0, 1'b0, 3'b011, 3'b111, 64'h0000_0040, 64'h0, 64'h0,
            0, 1'b0, 8'h00, 64'h0, 1'b1, 64'h0, 1'b0, 1);
`ifdef LSU_MISALIGN_CHK_EN
      issue(1'b1, 1'b0, 3'b011, 3'b000, 64'h0000_0002, 64'h0, 64'h0000_8000_0000_0000,
            0, 1'b0, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1, 1);
      issue(1'b0, 1'b1, 3'b000, 3'b110, 64'h0000_0006, 64'h1122_3344, 64'h0,
            0, 1'b0, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1, 1);
`else
      load(3'b011, 64'h0000_0002, 64'h0000_8000_0000_0000, 0, 64'hFFFF_FFFF_8000_0000);
      store(3'b110, 64'h0000_0006, 64'h0000_0000_1122_3344, 8'hC0, 64'h3344_0000_0000_0000);
`endif
      wait_idle();

      // Reset while waiting for the read response
      bus_drop = 1'b1;
      bus_rdata = 64'h5555_5555_5555_5555;
      issue(1'b1, 1'b0, 3'b100, 3'b000, 64'h0000_0080, 64'h0, 64'h5555_5555_5555_5555,
            0, 1'b1, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0, 0);
      n = 0;
      while (!mem_valid && n < 50) begin @(posedge clock); #1; n++; end
      while (mem_valid && n < 50) begin @(posedge clock); #1; n++; end
      chk("reached_wait", (n < 50), 1);
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_mem_valid", mem_valid, 0);
      chk("midrst_done_valid", done_valid, 0);
      #2;
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("postrst_req_ready", req_ready, 1);
      inject_req++;
      repeat (4) @(posedge clock);
      #1;
      chk("late_rsp_idle", req_ready, 1);
      chk("late_rsp_rdata", done_rdata, 0);
      bus_drop = 1'b0;

      // Normal operation resumes after the reset
      load(3'b001, 64'h0000_0007, 64'h7F00_0000_0000_0000, 0, 64'h0000_0000_0000_007F);
      wait_idle();
      chk("bus_q_empty", bus_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  execute stage presents an access; req_ready  out  1  unit idle and accepting.
REQ-004 req_mem_read / req_mem_write  in  1 each  decoded memory control.
REQ-005 req_load_type / req_store_type  in  3 each  decoded size/sign codes from defines.v.
REQ-006 req_addr  in  64  byte address; req_wdata  in  64  store data, right-aligned.
REQ-007 mem_valid  out  1  bus request; mem_ready  in  1  bus accepted the request.
REQ-008 mem_addr  out  64  req_addr with bits [2:0] cleared; mem_wen  out  1  write request.
REQ-009 mem_wmask  out  8  byte strobes; mem_wdata  out  64  lane-shifted store data.
REQ-010 mem_rsp_valid  in  1  read data or write acknowledge; mem_rdata  in  64  aligned doubleword.
REQ-011 done_valid  out  1  one-cycle completion pulse; done_rdata  out  64  extended load result.
REQ-012 done_err  out  1  misaligned access flag, only with LSU_MISALIGN_CHK_EN.

Function
REQ-013 FSM states: IDLE, REQ, WAIT, DONE; req_ready = (state==IDLE).
REQ-014 IDLE: req_valid with read or write set -> latch all req_* fields, go REQ; neither set -> go DONE, done_rdata=0.
REQ-015 Read and write both set: the access is a store.
REQ-016 REQ: mem_valid=1 with latched fields held stable; mem_ready=1 -> WAIT; otherwise stay in REQ.
REQ-017 WAIT: mem_rsp_valid=1 -> capture mem_rdata, go DONE; otherwise stay in WAIT.
REQ-018 mem_rsp_valid outside WAIT is ignored.
REQ-019 DONE: done_valid=1 for exactly one cycle, then IDLE.
REQ-020 Minimum latency, zero-wait bus: acceptance at cycle N, mem_valid at N+1, done_valid at N+3.
REQ-021 Store codes: 100 sb, 101 sh, 110 sw, 111 sd.
REQ-022 Store mask = (0x01/0x03/0x0F/0xFF) << addr[2:0]; mem_wdata = req_wdata << 8*addr[2:0]; bits beyond 64 dropped.
REQ-023 Load codes: 001 lb, 101 lbu, 010 lh, 110 lhu, 011 lw, 111 lwu, 100 ld.
REQ-024 Load result = (mem_rdata >> 8*addr[2:0]) truncated to size; sign-extended when code[2]=0, zero-extended otherwise; ld unmodified.
REQ-025 Load mem_wmask=0, mem_wen=0; done_rdata=0 for stores.
REQ-026 done_rdata holds until the next DONE.

Reset
REQ-027 Assertion forces IDLE immediately, mid-transaction included; any pending bus request is dropped.
REQ-028 Reset values: mem_valid, mem_wen, done_valid, done_err = 0; mem_addr, mem_wmask, mem_wdata, done_rdata = 0.
REQ-029 req_ready = 1 in the first cycle after deassertion.

Configuration
REQ-030 LSU_MISALIGN_CHK_EN defined: an access whose address is not size-aligned (h: addr[0]; w: addr[1:0]; d: addr[2:0]) goes IDLE -> DONE with no bus request.
REQ-031 That access gives done_err=1 for the DONE cycle and done_rdata=0.
REQ-032 LSU_MISALIGN_CHK_EN undefined: done_err is tied 0; misaligned accesses issue normally and byte lanes beyond bit 63 are dropped.

Structure
REQ-033 Load/store type encodings, state encodings and bus-width macros live in defines.v, shared with the decoder.
REQ-034 Sub-module lsu_load_ext: combinational shift, truncate and extend of mem_rdata by load type and addr[2:0].

Verification
REQ-035 sd addr 0x8000_0000, wdata 0x1122334455667788 -> mem_wmask 0xFF, mem_wdata unchanged, done_valid at N+3.
REQ-036 sb addr 0x8000_0005, wdata 0xAB -> mem_addr 0x8000_0000, mem_wmask 0x20, mem_wdata[47:40]=0xAB.
REQ-037 lb addr ...0x3, mem_rdata 0x0000_0000_8000_0000 -> done_rdata 0xFFFF_FFFF_FFFF_FF80; lbu -> 0x80.
REQ-038 lw addr ...0x4, mem_ready held low 3 cycles, mem_rdata 0x8765_4321_0000_0000 -> mem_valid stable 4 cycles, done_rdata 0xFFFF_FFFF_8765_4321.
REQ-039 reset_n pulsed low during WAIT -> next cycle IDLE, no done_valid; a late mem_rsp_valid is ignored.
REQ-040 With LSU_MISALIGN_CHK_EN, lw addr ...0x2 -> no mem_valid, done_valid with done_err=1 at N+1.
